// File: rtl/train_seq_pkg.sv
// train_seq_pkg: state encoding and counter sizing shared by the sequencer and its bench
package train_seq_pkg;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_UPDATE = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  typedef enum logic [2:0] {
    IDLE = S_IDLE,
    CLR = S_CLR,
    FETCH = S_FETCH,
    HOLD = S_HOLD,
    UPDATE = S_UPDATE,
    DONE = S_DONE
  } state_t;
  localparam int BATCH_DEF = 4;
  localparam int N_HOLD_DEF = 4;
  function automatic int cnt_w(int batch, int n_hold);
    return $clog2((batch > n_hold ? batch : n_hold) + 1);
  endfunction
endpackage

// File: rtl/train_seq_if.sv
// train_seq_if: valid/ready sample stream carrying one (input, target) pair
interface train_seq_if #(
  parameter int N_IN = 2,
  parameter int N_OUT = 2,
  parameter int WIDTH = 32
);
  logic s_valid;
  logic s_ready;
  logic [N_IN*WIDTH-1:0] s_k;
  logic [N_OUT*WIDTH-1:0] s_t;
  modport master (output s_valid, s_k, s_t, input s_ready);
  modport slave (input s_valid, s_k, s_t, output s_ready);
endinterface

// File: rtl/train_seq.sv
// train_seq: fetches samples, holds them for the array and sequences load/accu/wr/rst_btch per mini-batch
module train_seq
  import train_seq_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int N_OUT = 2,
  parameter int WIDTH = 32,
  parameter int BATCH = BATCH_DEF,
  parameter int N_HOLD = N_HOLD_DEF,
  parameter int LOAD_AT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic [15:0] i_n_epoch,
  input  logic [WIDTH-1:0] i_lr,
  train_seq_if.slave s,
  input  logic [WIDTH-1:0] i_cost,
  output logic [N_IN*WIDTH-1:0] o_k,
  output logic [N_OUT*WIDTH-1:0] o_t,
  output logic [WIDTH-1:0] o_lr,
  output logic o_load,
  output logic o_accu,
  output logic o_wr,
  output logic o_rst_btch,
  output logic [WIDTH-1:0] o_batch_cost,
  output logic [15:0] o_epoch,
  output logic o_busy,
  output logic o_done
);
  localparam int CW = cnt_w(BATCH, N_HOLD);
  localparam logic [CW-1:0] HLAST = CW'(N_HOLD - 1);
  localparam logic [CW-1:0] BLAST = CW'(BATCH - 1);
  localparam logic [CW-1:0] LOAD = CW'(LOAD_AT);
  state_t state, nxt;
  logic [CW-1:0] hold_cnt, smp_cnt;
  logic [WIDTH-1:0] acc;
  logic [15:0] n_ep;
  logic start_ok, fire;
  assign start_ok = (state == IDLE || state == DONE) && i_start;
  assign fire = state == HOLD && hold_cnt == HLAST;
  assign s.s_ready = !rst && state == FETCH;
  assign o_load = !rst && state == HOLD && hold_cnt == LOAD;
  assign o_accu = !rst && fire;
  assign o_wr = !rst && state == UPDATE;
  assign o_rst_btch = !rst && state == CLR;
  assign o_busy = state != IDLE && state != DONE;
  assign o_done = state == DONE;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  // next-state decode
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE: nxt = i_start ? (i_n_epoch == 16'd0 ? DONE : CLR) : state;
      CLR: nxt = FETCH;
      FETCH: nxt = s.s_valid ? HOLD : FETCH;
      HOLD: nxt = fire ? (smp_cnt == BLAST ? UPDATE : FETCH) : HOLD;
      UPDATE: nxt = o_epoch + 16'd1 == n_ep ? DONE : CLR;
      default: nxt = IDLE;
    endcase
  end
  // sample capture, counters and cost accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      o_k <= '0;
      o_t <= '0;
      o_lr <= '0;
      o_batch_cost <= '0;
      o_epoch <= '0;
      n_ep <= '0;
      hold_cnt <= '0;
      smp_cnt <= '0;
      acc <= '0;
    end else begin
      if (start_ok) begin
        o_lr <= i_lr;
        n_ep <= i_n_epoch;
        o_epoch <= '0;
        smp_cnt <= '0;
        hold_cnt <= '0;
        acc <= '0;
      end
      if (state == CLR) begin
        acc <= '0;
        smp_cnt <= '0;
      end
      if (state == FETCH && s.s_valid) begin
        o_k <= s.s_k;
        o_t <= s.s_t;
        hold_cnt <= '0;
      end
      if (state == HOLD) hold_cnt <= hold_cnt + CW'(1);
      if (fire) begin
        acc <= acc + i_cost;
        smp_cnt <= smp_cnt + CW'(1);
      end
      if (state == UPDATE) begin
        o_batch_cost <= acc;
        o_epoch <= o_epoch + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_train_seq.sv
// tb_train_seq: directed vector table plus reset, backpressure and busy-start sequences
module tb_train_seq;
  logic clk = 0, rst = 1, i_start = 0;
  logic [15:0] i_n_epoch = '0;
  logic [31:0] i_lr = '0, i_cost = '0;
  logic [63:0] o_k, o_t;
  logic [31:0] o_lr, o_batch_cost;
  logic o_load, o_accu, o_wr, o_rst_btch, o_busy, o_done;
  logic [15:0] o_epoch;
  int n_chk = 0, n_pass = 0;
  train_seq_if #(.N_IN(2), .N_OUT(2), .WIDTH(32)) sif ();
  train_seq #(.N_IN(2), .N_OUT(2), .WIDTH(32), .BATCH(4), .N_HOLD(4), .LOAD_AT(1)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_n_epoch(i_n_epoch), .i_lr(i_lr),
    .s(sif.slave), .i_cost(i_cost), .o_k(o_k), .o_t(o_t), .o_lr(o_lr),
    .o_load(o_load), .o_accu(o_accu), .o_wr(o_wr), .o_rst_btch(o_rst_btch),
    .o_batch_cost(o_batch_cost), .o_epoch(o_epoch), .o_busy(o_busy), .o_done(o_done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] cost, lr;
    logic [15:0] n_ep;
    logic [63:0] k, t;
    int done_c, wr_c, load_c, accu_c, n_wr, n_accu, n_load, n_rst;
    logic [31:0] bc;
    logic [15:0] ep;
  } vec_t;
  vec_t v[5];
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic [3:0] strb();
    return {o_load, o_accu, o_wr, o_rst_btch};
  endfunction
  initial begin
    int c, t, done_c, wr_c, load_c, accu_c, n_wr, n_accu, n_load, n_rst, n_excl;
    int bad_rdy, bad_k, bad_s;
    v[0] = '{32'h0100_0000, 32'h0000_1000, 16'd1, 64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD,
             23, 22, 4, 6, 1, 4, 4, 1, 32'h0400_0000, 16'd1};
    v[1] = '{32'h7FFF_FFFF, 32'h0000_2000, 16'd1, 64'h5555_6666_7777_8888, 64'h0123_4567_89AB_CDEF,
             23, 22, 4, 6, 1, 4, 4, 1, 32'hFFFF_FFFC, 16'd1};
    v[2] = '{32'h0000_0005, 32'h0000_3000, 16'd3, 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004,
             67, 22, 4, 6, 3, 12, 12, 3, 32'h0000_0014, 16'd3};
    v[3] = '{32'hFFFF_FFFF, 32'h0000_4000, 16'd2, 64'hDEAD_BEEF_CAFE_F00D, 64'h1357_9BDF_2468_ACE0,
             45, 22, 4, 6, 2, 8, 8, 2, 32'hFFFF_FFFC, 16'd2};
    v[4] = '{32'h0000_0009, 32'h0000_5000, 16'd0, 64'hDEAD_BEEF_CAFE_F00D, 64'h1357_9BDF_2468_ACE0,
             1, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 16'd0};
    sif.s_valid = 1;
    sif.s_k = '0;
    sif.s_t = '0;
    repeat (2) @(negedge clk);
    check("rst_lr", {32'h0, o_lr}, 64'h0);
    check("rst_busy", {62'h0, o_busy, o_done}, 64'h0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      i_cost = v[i].cost;
      i_lr = v[i].lr;
      i_n_epoch = v[i].n_ep;
      sif.s_k = v[i].k;
      sif.s_t = v[i].t;
      @(negedge clk) i_start = 1;
      @(negedge clk) i_start = 0;
      c = 1;
      {done_c, wr_c, load_c, accu_c, n_wr, n_accu, n_load, n_rst, n_excl} = '0;
      while (!o_done && c < 400) begin
        if (o_wr && wr_c == 0) wr_c = c;
        if (o_load && load_c == 0) load_c = c;
        if (o_accu && accu_c == 0) accu_c = c;
        n_wr += int'(o_wr);
        n_accu += int'(o_accu);
        n_load += int'(o_load);
        n_rst += int'(o_rst_btch);
        if ($countones(strb()) > 1) n_excl++;
        c++;
        @(negedge clk);
      end
      done_c = o_done ? c : -1;
      check($sformatf("v%0d_done_cycle", i), 64'(done_c), 64'(v[i].done_c));
      check($sformatf("v%0d_wr_cycle", i), 64'(wr_c), 64'(v[i].wr_c));
      check($sformatf("v%0d_load_cycle", i), 64'(load_c), 64'(v[i].load_c));
      check($sformatf("v%0d_accu_cycle", i), 64'(accu_c), 64'(v[i].accu_c));
      check($sformatf("v%0d_n_wr", i), 64'(n_wr), 64'(v[i].n_wr));
      check($sformatf("v%0d_n_accu", i), 64'(n_accu), 64'(v[i].n_accu));
      check($sformatf("v%0d_n_load", i), 64'(n_load), 64'(v[i].n_load));
      check($sformatf("v%0d_n_rst_btch", i), 64'(n_rst), 64'(v[i].n_rst));
      check($sformatf("v%0d_exclusive", i), 64'(n_excl), 64'h0);
      check($sformatf("v%0d_batch_cost", i), {32'h0, o_batch_cost}, {32'h0, v[i].bc});
      check($sformatf("v%0d_epoch", i), {48'h0, o_epoch}, {48'h0, v[i].ep});
      check($sformatf("v%0d_lr", i), {32'h0, o_lr}, {32'h0, v[i].lr});
      check($sformatf("v%0d_k", i), o_k, v[i].k);
      check($sformatf("v%0d_t", i), o_t, v[i].t);
      check($sformatf("v%0d_busy", i), {63'h0, o_busy}, 64'h0);
    end
    // reset in the middle of a hold window, at the cycle load would pulse
    i_cost = 32'h0000_0001;
    i_n_epoch = 16'd1;
    @(negedge clk) i_start = 1;
    @(negedge clk) i_start = 0;
    repeat (3) @(negedge clk);
    check("pre_rst_load", {63'h0, o_load}, 64'h1);
    rst = 1;
    #1;
    check("rst_cycle_strobes", {60'h0, strb()}, 64'h0);
    @(negedge clk) rst = 0;
    check("rst_idle", {62'h0, o_busy, o_done}, 64'h0);
    check("rst_ready", {63'h0, sif.s_ready}, 64'h0);
    check("rst_k", o_k, 64'h0);
    check("rst_t", o_t, 64'h0);
    check("rst_lr_cost", {o_lr, o_batch_cost}, 64'h0);
    check("rst_epoch", {48'h0, o_epoch}, 64'h0);
    check("rst_strobes_1", {60'h0, strb()}, 64'h0);
    @(negedge clk);
    check("rst_strobes_2", {60'h0, strb()}, 64'h0);
    // backpressure: source runs dry after the first sample, then a start arrives while busy
    i_lr = 32'h0000_0111;
    sif.s_k = 64'h0000_00AA_0000_00BB;
    @(negedge clk) i_start = 1;
    @(negedge clk) i_start = 0;
    repeat (5) @(negedge clk);
    sif.s_valid = 0;
    sif.s_k = 64'h0000_00CC_0000_00DD;
    {bad_rdy, bad_k, bad_s} = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sif.s_ready !== 1'b1) bad_rdy++;
      if (o_k !== 64'h0000_00AA_0000_00BB) bad_k++;
      if (strb() !== 4'b0) bad_s++;
    end
    check("bp_ready_held", 64'(bad_rdy), 64'h0);
    check("bp_k_held", 64'(bad_k), 64'h0);
    check("bp_no_strobes", 64'(bad_s), 64'h0);
    sif.s_valid = 1;
    i_lr = 32'h0000_0999;
    i_n_epoch = 16'd0;
    i_start = 1;
    @(negedge clk) i_start = 0;
    check("bp_resume_k", o_k, 64'h0000_00CC_0000_00DD);
    check("busy_start_lr", {32'h0, o_lr}, 64'h0000_0111);
    check("busy_start_busy", {63'h0, o_busy}, 64'h1);
    t = 0;
    while (!o_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("bp_done", {63'h0, o_done}, 64'h1);
    check("bp_batch_cost", {32'h0, o_batch_cost}, 64'h4);
    check("bp_epoch", {48'h0, o_epoch}, 64'h1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
